// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared state, memory-op codes and helpers for the CPU control path
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    localparam logic [1:0] MEMOP_NONE  = 2'b00;
    localparam logic [1:0] MEMOP_LOAD  = 2'b01;
    localparam logic [1:0] MEMOP_STORE = 2'b10;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

    // The reserved encoding 2'b11 deliberately falls through as a non-memory op.
    function automatic logic is_mem_access(input logic [1:0] op);
        return (op == MEMOP_LOAD) || (op == MEMOP_STORE);
    endfunction

    function automatic logic pc_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - multi-cycle fetch/decode/exec/mem/wb sequencer owning the PC
module pc_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter int          INSTRET_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 imem_req,
    input  logic                 imem_ready,
    input  logic [1:0]           mem_op,
    output logic                 dmem_req,
    input  logic                 dmem_ready,
    input  logic [31:0]          npc,
    input  logic                 stall,
    output logic [31:0]          pc,
    output logic                 ir_we,
    output logic                 ex_en,
    output logic                 wb_en,
    output logic                 misalign,
    output logic                 halted,
    output logic [INSTRET_W-1:0] instret
);

    state_e                 state_q, state_d;
    logic [31:0]            pc_q, pc_d;
    logic [INSTRET_W-1:0]   instret_q, instret_d;
    logic                   misalign_q, misalign_d;
    logic                   imem_req_q;
    logic                   dmem_req_q;
    logic                   halted_q;
    logic                   ir_we_c, ex_en_c, wb_en_c;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instret_d  = instret_q;
        misalign_d = misalign_q;
        ir_we_c    = 1'b0;
        ex_en_c    = 1'b0;
        wb_en_c    = 1'b0;

        case (state_q)
            // A fetch only completes against a request that is actually on the bus,
            // so the reset-release cycle (request still low) cannot capture a word.
            ST_FETCH: begin
                if (imem_req_q && imem_ready) begin
                    ir_we_c = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (!stall) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!stall) begin
                    ex_en_c = 1'b1;
                    state_d = is_mem_access(mem_op) ? ST_MEM : ST_WB;
                end
            end
            ST_MEM: begin
                if (dmem_req_q && dmem_ready) begin
                    state_d = ST_WB;
                end
            end
            // The instruction retires even when its successor address faults.
            ST_WB: begin
                if (!stall) begin
                    wb_en_c   = 1'b1;
                    instret_d = instret_q + INSTRET_W'(1);
                    if (pc_aligned(npc)) begin
                        pc_d    = npc;
                        state_d = ST_FETCH;
                    end else begin
                        misalign_d = 1'b1;
                        state_d    = ST_TRAP;
                    end
                end
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_TRAP;
            end
        endcase
    end

    // Request and halt outputs are registered from the next state so they
    // line up with the state they belong to and clear the instant reset asserts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_VECTOR;
            instret_q  <= '0;
            misalign_q <= 1'b0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instret_q  <= instret_d;
            misalign_q <= misalign_d;
            imem_req_q <= (state_d == ST_FETCH);
            dmem_req_q <= (state_d == ST_MEM);
            halted_q   <= (state_d == ST_TRAP);
        end
    end

    assign imem_req = imem_req_q;
    assign dmem_req = dmem_req_q;
    assign halted   = halted_q;
    assign pc       = pc_q;
    assign instret  = instret_q;
    assign misalign = misalign_q;
    assign ir_we    = ir_we_c;
    assign ex_en    = ex_en_c;
    assign wb_en    = wb_en_c;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer with an instruction-level timeline model
module tb_pc_sequencer;

    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          imem_req;
    logic          imem_ready;
    logic [1:0]    mem_op;
    logic          dmem_req;
    logic          dmem_ready;
    logic [31:0]   npc;
    logic          stall;
    logic [31:0]   pc;
    logic          ir_we;
    logic          ex_en;
    logic          wb_en;
    logic          misalign;
    logic          halted;
    logic [IW-1:0] instret;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_pc;
    int          m_instret;
    logic        m_halt;

    pc_sequencer #(
        .RESET_VECTOR (32'h0000_0000),
        .INSTRET_W    (IW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_ready (imem_ready),
        .mem_op     (mem_op),
        .dmem_req   (dmem_req),
        .dmem_ready (dmem_ready),
        .npc        (npc),
        .stall      (stall),
        .pc         (pc),
        .ir_we      (ir_we),
        .ex_en      (ex_en),
        .wb_en      (wb_en),
        .misalign   (misalign),
        .halted     (halted),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string ph, input logic e_imem, input logic e_dmem,
                              input logic e_ir, input logic e_ex, input logic e_wb);
        chk({ph, ".imem_req"}, {31'b0, imem_req}, {31'b0, e_imem});
        chk({ph, ".dmem_req"}, {31'b0, dmem_req}, {31'b0, e_dmem});
        chk({ph, ".ir_we"},    {31'b0, ir_we},    {31'b0, e_ir});
        chk({ph, ".ex_en"},    {31'b0, ex_en},    {31'b0, e_ex});
        chk({ph, ".wb_en"},    {31'b0, wb_en},    {31'b0, e_wb});
        chk({ph, ".pc"},       pc,                m_pc);
        chk({ph, ".instret"},  {{(32-IW){1'b0}}, instret}, 32'(m_instret));
        chk({ph, ".halted"},   {31'b0, halted},   {31'b0, m_halt});
        chk({ph, ".misalign"}, {31'b0, misalign}, {31'b0, m_halt});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_inputs();
        imem_ready = 1'($urandom);
        dmem_ready = 1'($urandom);
        stall      = 1'($urandom);
        mem_op     = 2'($urandom);
        npc        = $urandom;
    endtask

    task automatic model_reset();
        m_pc      = 32'h0000_0000;
        m_instret = 0;
        m_halt    = 1'b0;
    endtask

    // Entered at posedge+1 of the cycle in which rst_n has just been released.
    task automatic after_reset();
        rnd_inputs();
        #4;
        check_outs("rel", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    // One instruction, driven open-loop from its expected phase lengths:
    // fetch iw+1, decode ds+1, exec es+1, mem dw+1 (loads/stores), wb ws+1.
    task automatic run_instr(input logic [1:0] op, input logic [31:0] nxt,
                             input int iw, input int ds, input int es,
                             input int dw, input int ws, input bit abort);
        bit is_mem;
        is_mem = (op == 2'b01) || (op == 2'b10);

        for (int j = 0; j <= iw; j++) begin
            rnd_inputs();
            imem_ready = (j == iw);
            #4;
            check_outs("fetch", 1'b1, 1'b0, j == iw, 1'b0, 1'b0);
            tick();
        end
        for (int j = 0; j <= ds; j++) begin
            rnd_inputs();
            stall = (j < ds);
            #4;
            check_outs("decode", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        for (int j = 0; j <= es; j++) begin
            rnd_inputs();
            stall  = (j < es);
            mem_op = op;
            #4;
            check_outs("exec", 1'b0, 1'b0, 1'b0, j == es, 1'b0);
            tick();
        end
        if (is_mem) begin
            for (int j = 0; j <= dw; j++) begin
                rnd_inputs();
                dmem_ready = (j == dw);
                if (abort && j == 1) dmem_ready = 1'b0;
                #4;
                check_outs("mem", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
                if (abort && j == 1) begin
                    rst_n = 1'b0;
                    #1;
                    model_reset();
                    check_outs("rst_in_mem", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                    tick();
                    rst_n = 1'b1;
                    return;
                end
                tick();
            end
        end
        for (int j = 0; j <= ws; j++) begin
            rnd_inputs();
            stall = (j < ws);
            if (j == ws) npc = nxt;
            #4;
            check_outs("wb", 1'b0, 1'b0, 1'b0, 1'b0, j == ws);
            tick();
        end
        m_instret = (m_instret + 1) % (1 << IW);
        if (nxt[1:0] == 2'b00) m_pc = nxt;
        else                   m_halt = 1'b1;
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] nxt;

        rst_n      = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        stall      = 1'b0;
        mem_op     = 2'b00;
        npc        = 32'h0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        imem_ready = 1'b1;
        #1;
        check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        after_reset();

        for (int j = 0; j < 3; j++) begin
            rnd_inputs();
            imem_ready = 1'b0;
            #4;
            check_outs("hold", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end

        run_instr(2'b00, 32'h0000_0004, 0, 0, 0, 0, 0, 1'b0);
        run_instr(2'b01, m_pc + 32'd4,  0, 0, 0, 3, 0, 1'b0);
        run_instr(2'b00, m_pc + 32'd4,  0, 0, 2, 0, 0, 1'b0);
        run_instr(2'b10, 32'h0000_1000, 1, 1, 0, 0, 2, 1'b0);
        run_instr(2'b11, 32'h0000_1004, 0, 0, 0, 0, 0, 1'b0);

        for (int k = 0; k < 24; k++) begin
            op  = 2'($urandom);
            nxt = $urandom & 32'hFFFF_FFFC;
            run_instr(op, nxt, $urandom_range(0, 2), $urandom_range(0, 2),
                      $urandom_range(0, 2), $urandom_range(0, 3),
                      $urandom_range(0, 2), 1'b0);
        end

        run_instr(2'b01, m_pc + 32'd4, 0, 0, 0, 3, 0, 1'b1);
        after_reset();

        run_instr(2'b00, 32'h0000_0010, 0, 1, 0, 0, 0, 1'b0);
        run_instr(2'b10, 32'h0000_0020, 2, 0, 1, 1, 1, 1'b0);

        run_instr(2'b00, 32'h0000_0102, 0, 0, 0, 0, 1, 1'b0);
        for (int j = 0; j < 5; j++) begin
            rnd_inputs();
            #4;
            check_outs("trap", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end

        rst_n = 1'b0;
        #1;
        model_reset();
        check_outs("rst_trap", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        after_reset();
        run_instr(2'b00, 32'h0000_0040, 0, 0, 0, 0, 0, 1'b0);
        rnd_inputs();
        #4;
        check_outs("final", 1'b1, 1'b0, imem_ready, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
